// File: rtl/syndrome_calc_pkg.sv
// Shared constants, state type and GF(16) helper for the RS(15,11) syndrome stage.
// GF(16) is built on the primitive polynomial x^4 + x + 1.
package syndrome_calc_pkg;

   localparam logic [4:0]  GF_POLY = 5'b10011;
   localparam int unsigned SYM_W   = 4;
   localparam int unsigned N_SYM   = 15;
   localparam int unsigned N_SYND  = 4;

   // Horner multipliers alpha^j for S1..S4
   localparam logic [SYM_W-1:0] ALPHA1 = 4'h2;
   localparam logic [SYM_W-1:0] ALPHA2 = 4'h4;
   localparam logic [SYM_W-1:0] ALPHA3 = 4'h8;
   localparam logic [SYM_W-1:0] ALPHA4 = 4'h3;

   localparam logic [N_SYND*SYM_W-1:0] ALPHA_VEC = {ALPHA4, ALPHA3, ALPHA2, ALPHA1};

   // symbol counter value at which the accepted beat is r0
   localparam logic [3:0] CNT_LAST = 4'(N_SYM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   // shift-and-add GF(16) multiply, reducing by GF_POLY on each shift
   function automatic logic [SYM_W-1:0] gf16_mul(input logic [SYM_W-1:0] a,
                                                 input logic [SYM_W-1:0] b);
      logic [SYM_W-1:0] p;
      logic [SYM_W-1:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < SYM_W; i++) begin
         if (b[i]) p = p ^ x;
         x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ GF_POLY[SYM_W-1:0])
                        : {x[SYM_W-2:0], 1'b0};
      end
      return p;
   endfunction

endpackage

// File: rtl/syndrome_calc_gf16_const_mul.sv
// Combinational GF(16) multiply by a constant MULT.
module gf16_const_mul
   import syndrome_calc_pkg::*;
#(
   parameter logic [SYM_W-1:0] MULT = 4'h1
) (
   input  logic [SYM_W-1:0] a_in,
   output logic [SYM_W-1:0] p_out
);

   // constant operand folds the multiply into a small XOR network
   always_comb begin
      p_out = gf16_mul(a_in, MULT);
   end

endmodule

// File: rtl/syndrome_calc.sv
// RS(15,11) syndrome stage: accumulates S1..S4 = r(alpha^j) by Horner's rule,
// one symbol per accepted beat, r14 first.
// Optional macro SYND_HOLD_EN adds SYND_READY and a DONE state that holds
// SYND_VALID until the consumer acknowledges.
module syndrome_calc
   import syndrome_calc_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [SYM_W-1:0]        SYM_IN,
   input  logic                    SYM_VALID,
   input  logic                    SYM_START,
`ifdef SYND_HOLD_EN
   input  logic                    SYND_READY,
`endif
   output logic                    SYM_READY,
   output logic [N_SYND*SYM_W-1:0] SYND_OUT,
   output logic                    SYND_VALID,
   output logic                    ERR_DET
);

   state_t                        state_q, state_d;
   logic [3:0]                    cnt_q, cnt_d;
   logic [N_SYND-1:0][SYM_W-1:0]  acc_q, acc_d;
   logic [N_SYND-1:0][SYM_W-1:0]  acc_mul;
   logic [N_SYND-1:0][SYM_W-1:0]  acc_new;
   logic [N_SYND*SYM_W-1:0]       synd_q, synd_d;
   logic                          synd_valid_q, synd_valid_d;
   logic                          err_det_q, err_det_d;
   logic                          accept;

   for (genvar g = 0; g < N_SYND; g++) begin : g_mul
      gf16_const_mul #(
         .MULT(ALPHA_VEC[g*SYM_W +: SYM_W])
      ) u_mul (
         .a_in (acc_q[g]),
         .p_out(acc_mul[g])
      );
   end

   // Horner step candidate for every syndrome
   always_comb begin
      for (int unsigned j = 0; j < N_SYND; j++) begin
         acc_new[j] = acc_mul[j] ^ SYM_IN;
      end
   end

   // handshake: only the DONE state back-pressures the symbol stream
   always_comb begin
      SYM_READY = (state_q != S_DONE);
      accept    = SYM_VALID & SYM_READY;
   end

   // next-state, counter, accumulator and result update
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      synd_d       = synd_q;
      err_det_d    = err_det_q;
      synd_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && SYM_START) begin
               acc_d   = {N_SYND{SYM_IN}};
               cnt_d   = 4'd1;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               if (SYM_START) begin
                  // restart wins over r0: the partial word is abandoned
                  acc_d = {N_SYND{SYM_IN}};
                  cnt_d = 4'd1;
               end else if (cnt_q == CNT_LAST) begin
                  acc_d        = acc_new;
                  synd_d       = acc_new;
                  err_det_d    = |acc_new;
                  synd_valid_d = 1'b1;
                  cnt_d        = '0;
`ifdef SYND_HOLD_EN
                  state_d      = S_DONE;
`else
                  state_d      = S_IDLE;
`endif
               end else begin
                  acc_d = acc_new;
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_DONE: begin
`ifdef SYND_HOLD_EN
            if (SYND_READY) begin
               state_d = S_IDLE;
            end else begin
               synd_valid_d = 1'b1;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and result registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         synd_q       <= '0;
         synd_valid_q <= 1'b0;
         err_det_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         synd_q       <= synd_d;
         synd_valid_q <= synd_valid_d;
         err_det_q    <= err_det_d;
      end
   end

   assign SYND_OUT   = synd_q;
   assign SYND_VALID = synd_valid_q;
   assign ERR_DET    = err_det_q;

endmodule

// File: tb/tb_syndrome_calc.sv
// Scoreboard bench for syndrome_calc; expected syndromes are hand-computed
// over GF(16) with x^4+x+1 (alpha^1..alpha^14 = 2,4,8,3,6,C,B,5,A,7,E,F,D,9).
module tb_syndrome_calc;

   logic        CLK;
   logic        RESET;
   logic [3:0]  SYM_IN;
   logic        SYM_VALID;
   logic        SYM_START;
   logic        SYM_READY;
   logic [15:0] SYND_OUT;
   logic        SYND_VALID;
   logic        ERR_DET;
`ifdef SYND_HOLD_EN
   logic        SYND_READY;
`endif

   syndrome_calc dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .SYM_IN    (SYM_IN),
      .SYM_VALID (SYM_VALID),
      .SYM_START (SYM_START),
`ifdef SYND_HOLD_EN
      .SYND_READY(SYND_READY),
`endif
      .SYM_READY (SYM_READY),
      .SYND_OUT  (SYND_OUT),
      .SYND_VALID(SYND_VALID),
      .ERR_DET   (ERR_DET)
   );

   typedef struct {
      logic [15:0] synd;
      logic        err;
      int          cyc;
      int          width;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // monitor: pops the scoreboard on each SYND_VALID rise
   exp_t cur;
   logic vprev = 1'b0;
   int   run = 0;
   initial begin
      cur = '{synd: 16'h0, err: 1'b0, cyc: 0, width: 1};
      forever begin
         @(negedge CLK);
         if (SYND_VALID && !vprev) begin
            if (q.size() == 0) begin
               check("unexpected_valid", 32'(SYND_OUT), 32'hDEAD);
            end else begin
               cur = q.pop_front();
               check("synd_out", 32'(SYND_OUT), 32'(cur.synd));
               check("err_det", 32'(ERR_DET), 32'(cur.err));
               check("valid_latency", 32'(cyc), 32'(cur.cyc));
            end
            run = 1;
         end else if (SYND_VALID && vprev) begin
            run++;
         end else if (!SYND_VALID && vprev) begin
            check("valid_width", 32'(run), 32'(cur.width));
         end
`ifdef SYND_HOLD_EN
         if (SYND_VALID) check("sym_ready_in_done", 32'(SYM_READY), 32'h0);
`endif
         vprev = SYND_VALID;
      end
   end

   // drive nbeats of word w (r14 in bits 59:56); a full word queues its expectation
   task automatic send_word(input logic [59:0] w, input int unsigned nbeats, input bit gap,
                            input logic [15:0] es, input int ew);
      int unsigned t;
      for (int unsigned i = 0; i < nbeats; i++) begin
         SYM_VALID = 1'b1;
         SYM_START = (i == 0);
         SYM_IN    = w[4*(14-i) +: 4];
         t = 0;
         while (!SYM_READY && t < 100) begin
            @(posedge CLK); #1;
            t++;
         end
         if (t == 100) check("sym_ready_timeout", 32'(SYM_READY), 32'h1);
         @(posedge CLK); #1;
         SYM_VALID = 1'b0;
         SYM_START = 1'b0;
         if (gap && i < nbeats - 1) begin
            @(posedge CLK); #1;
         end
      end
      if (nbeats == 15) q.push_back('{synd: es, err: (es != 16'h0), cyc: cyc, width: ew});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET     = 1'b1;
      SYM_IN    = 4'h0;
      SYM_VALID = 1'b0;
      SYM_START = 1'b0;
`ifdef SYND_HOLD_EN
      SYND_READY = 1'b1;
`endif
      #1;
      check("rst_synd_out", 32'(SYND_OUT), 32'h0);
      check("rst_synd_valid", 32'(SYND_VALID), 32'h0);
      check("rst_err_det", 32'(ERR_DET), 32'h0);
      check("rst_sym_ready", 32'(SYM_READY), 32'h1);
      @(posedge CLK); @(posedge CLK); #1;
      RESET = 1'b0;

      // basic words
      send_word(60'h0, 15, 1'b0, 16'h0000, 1);
      send_word(60'h1, 15, 1'b0, 16'h1111, 1);
      send_word(60'h10, 15, 1'b0, 16'h3842, 1);
      send_word({4'h1, 56'h0}, 15, 1'b0, 16'hEFD9, 1);
      send_word({4'h1, 52'h0, 4'h1}, 15, 1'b0, 16'hFEC8, 1);

      // gapped word equals the unbroken result
      send_word(60'h10, 15, 1'b1, 16'h3842, 1);

      // 15 stray beats in IDLE must produce nothing
      for (int unsigned i = 0; i < 15; i++) begin
         SYM_VALID = 1'b1;
         SYM_IN    = 4'hF;
         @(posedge CLK); #1;
      end
      SYM_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("stray_synd_out", 32'(SYND_OUT), 32'h3842);

      // restart at cnt 7, then a full r0=1 word
      send_word({4'h5, 56'h0}, 7, 1'b0, 16'h0, 1);
      send_word(60'h1, 15, 1'b0, 16'h1111, 1);

      // asynchronous reset at cnt 9
      send_word({4'h1, 56'h0}, 9, 1'b0, 16'h0, 1);
      #2 RESET = 1'b1;
      #1;
      check("midrst_synd_out", 32'(SYND_OUT), 32'h0);
      check("midrst_synd_valid", 32'(SYND_VALID), 32'h0);
      check("midrst_err_det", 32'(ERR_DET), 32'h0);
      check("midrst_sym_ready", 32'(SYM_READY), 32'h1);
      @(posedge CLK); #1;
      RESET = 1'b0;
      send_word({4'h1, 56'h0}, 15, 1'b0, 16'hEFD9, 1);

`ifdef SYND_HOLD_EN
      // consumer holds off for 5 cycles after entering DONE
      SYND_READY = 1'b0;
      send_word(60'h1, 15, 1'b0, 16'h1111, 6);
      repeat (5) @(posedge CLK);
      #1;
      SYND_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check("hold_released_ready", 32'(SYM_READY), 32'h1);
      send_word(60'h10, 15, 1'b0, 16'h3842, 1);
`else
      // back-to-back words, second START in the pulse cycle
      send_word(60'h1, 15, 1'b0, 16'h1111, 1);
      send_word(60'h10, 15, 1'b0, 16'h3842, 1);
`endif

      repeat (5) @(posedge CLK);
      #1;
      check("scoreboard_empty", 32'(q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
